// File: rtl/rip_pipe_ctrl.sv
// Pipeline valid/stall/flush controller with run/drain/halt FSM and saturating performance counters.
// Latency: stage_state and fetch_en are combinational from the valid flops and this cycle's stall/flush; state and counters update on the next rising edge.
// Backpressure: stall_req holds a stage and everything younger; flush_req kills younger stages; halt_req stops fetch and drains the pipeline.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   start, halt_req           FSM control pulses
//   stall_req, flush_req      per-stage hazard requests (bit i = stage i; stage 0 youngest)
//   clr_cnt                   synchronous clear of all counters
//   stage_state               per stage {INVALID,STALL,READY}, stage i at [3i+2:3i]
//   fetch_en, halted          stage 0 load enable; FSM in HALTED
//   cycle_cnt .. flush_cnt    saturating performance counters
module rip_pipe_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    halt_req,
    input  logic [NUM_STAGES-1:0]   stall_req,
    input  logic [NUM_STAGES-1:0]   flush_req,
    input  logic                    clr_cnt,
    output logic [3*NUM_STAGES-1:0] stage_state,
    output logic                    fetch_en,
    output logic                    halted,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_STAGES-1:0]   v_q, v_d;
    logic [CNT_W-1:0]        cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]        retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;

    logic                    run;
    logic                    flush_any;
    logic [NUM_STAGES-1:0]   flush_above;  // a flush bit exists at an index strictly above i (i < f)
    logic [NUM_STAGES-1:0]   stall_eff;    // stall requests at or above the flushing stage
    logic [NUM_STAGES-1:0]   hold;         // prefix mask: 1 for every i <= s
    logic [NUM_STAGES-1:0]   hold_top;     // single bit at s
    logic                    stall_any;
    logic                    stall_valid;
    logic                    retire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    assign run = (state_q == ST_RUN);

    // Hazard decode. Both priority encoders are expressed as suffix-OR masks so
    // no index arithmetic is needed: hold is the OR of stall_eff from i upward,
    // which is exactly "i <= highest surviving stall".
    always_comb begin
        flush_above = '0;
        stall_eff   = '0;
        hold        = '0;
        hold_top    = '0;

        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            flush_above[i] = flush_above[i+1] | flush_req[i+1];
        end
        flush_any = |flush_req;

        // A stall below the flushing stage belongs to an instruction being killed.
        stall_eff = stall_req & ~flush_above;
        stall_any = |stall_eff;

        hold[NUM_STAGES-1] = stall_eff[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            hold[i] = hold[i+1] | stall_eff[i];
        end

        hold_top[NUM_STAGES-1] = hold[NUM_STAGES-1];
        for (int i = 0; i < NUM_STAGES - 1; i++) begin
            hold_top[i] = hold[i] & ~hold[i+1];
        end

        stall_valid = |(hold_top & v_q);
        retire      = v_q[NUM_STAGES-1] & ~hold[NUM_STAGES-1];
    end

    // Valid-bit advance.
    always_comb begin
        v_d    = '0;
        v_d[0] = hold[0] ? v_q[0] : run;
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (hold[i]) begin
                v_d[i] = v_q[i];
            end else if (hold[i-1]) begin
                v_d[i] = 1'b0;           // bubble behind the oldest held stage
            end else if (flush_above[i]) begin
                v_d[i] = 1'b0;           // younger than the flushing stage
            end else begin
                v_d[i] = v_q[i-1];
            end
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (v_q == '0) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters: clear wins over increment.
    always_comb begin
        cycle_cnt_d  = sat_inc(cycle_cnt_q, (state_q == ST_RUN) || (state_q == ST_DRAIN));
        retire_cnt_d = sat_inc(retire_cnt_q, retire);
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_any & stall_valid);
        flush_cnt_d  = sat_inc(flush_cnt_q, flush_any);
        if (clr_cnt) begin
            cycle_cnt_d  = '0;
            retire_cnt_d = '0;
            stall_cnt_d  = '0;
            flush_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            v_q          <= '0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Outputs.
    always_comb begin
        stage_state = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (!v_q[i]) begin
                stage_state[3*i +: 3] = 3'b100;
            end else if (hold[i]) begin
                stage_state[3*i +: 3] = 3'b010;
            end else begin
                stage_state[3*i +: 3] = 3'b001;
            end
        end
    end

    assign fetch_en   = run & ~hold[0];
    assign halted     = (state_q == ST_HALTED);
    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
